cart_dl_writer: RTL and testbench
=================================

CART_DL_WRITER -- requirements
Module: cart_dl_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered download words (power of two, min 2).
REQ-002 SHALL have parameter AW, default 25, ioctl byte-address width.
REQ-003 SHALL have port clk_sys  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port cart_download  in  1  high while the cartridge ROM image is being streamed.
REQ-006 SHALL have port ioctl_wr  in  1  one-cycle strobe, one 16-bit word valid.
REQ-007 SHALL have port ioctl_addr  in  AW  byte address of the word (always even).
REQ-008 SHALL have port ioctl_dout  in  16  data; [7:0] = byte at addr, [15:8] = byte at addr+1.
REQ-009 SHALL have port ioctl_wait  out  1  back-pressure to the download source.
REQ-010 SHALL have port mem_req  out  1  SDRAM write request, level.
REQ-011 SHALL have port mem_addr  out  AW-1  word address (ioctl_addr[AW-1:1]).
REQ-012 SHALL have port mem_din  out  16  write data.
REQ-013 SHALL have port mem_ack  in  1  one-cycle write-complete strobe from SDRAM controller.
REQ-014 SHALL have port rom_bytes  out  AW  image size = highest accepted address + 2.
REQ-015 SHALL have port hdr_ok  out  1  header checksum at 0x14D matched.
REQ-016 SHALL have port overflow  out  1  sticky: word arrived while FIFO full.
REQ-017 SHALL have port dl_done  out  1  one-cycle pulse, all words committed after download end.

Function
REQ-018 SHALL accept a word on every cycle with cart_download & ioctl_wr & FIFO not full, pushing {addr, data}.
REQ-019 SHALL assert ioctl_wait, registered, whenever FIFO occupancy >= FIFO_DEPTH-1, leaving one slot for an in-flight strobe.
REQ-020 SHALL drop the word and set overflow when ioctl_wr arrives with FIFO full; overflow holds until next download start or reset.
REQ-021 SHALL ignore ioctl_wr while cart_download is low.
REQ-022 SHALL run write FSM states IDLE, REQ: IDLE->REQ when FIFO non-empty; REQ holds mem_req=1 and stable mem_addr/mem_din until mem_ack; on mem_ack pop head, mem_req=0 next cycle, return IDLE.
REQ-023 SHALL assert mem_req no earlier than the cycle after the push edge (minimum latency 1 cycle, push to request).
REQ-024 SHALL support simultaneous push and pop in one cycle with occupancy unchanged.
REQ-025 SHALL ignore mem_ack while mem_req is low.
REQ-026 SHALL on cart_download rising edge clear rom_bytes, hdr_ok, overflow and the checksum accumulator; FIFO contents are not flushed.
REQ-027 SHALL update rom_bytes on each accepted word to max(rom_bytes, ioctl_addr+2), AW-bit, no wrap handling beyond AW bits.
REQ-028 SHALL compute 8-bit checksum x=0; x=x-b-1 (mod 256) over bytes 0x134..0x14C, using both bytes of words 0x134..0x14A and low byte of word 0x14C.
REQ-029 SHALL on accepting word 0x14C set hdr_ok = (final x == ioctl_dout[15:8]) in the same update; hdr_ok stays 0 if word 0x14C never arrives.
REQ-030 SHALL evaluate checksum only on first-pass header words (ioctl_addr[AW-1:12]==0); duplicates are folded in arrival order.
REQ-031 SHALL on cart_download falling edge enter drain; pulse dl_done for exactly one cycle once FIFO empty and FSM in IDLE (same cycle as last pop +1).
REQ-032 SHALL abort drain without dl_done if cart_download rises again before drain completes.
REQ-033 SHALL not change FIFO or FSM state on download start while a request is outstanding.

Reset
REQ-034 SHALL on reset: FIFO empty, FSM IDLE, mem_req=0, ioctl_wait=0, dl_done=0, overflow=0, hdr_ok=0, rom_bytes=0, mem_addr/mem_din=0.
REQ-035 SHALL, on reset mid-transfer, drop mem_req at the next edge and discard buffered words; any later mem_ack is ignored.

Verification
REQ-036 Single word 0x0000=0xC3A5, mem_ack 3 cycles after req -> mem_addr=0, mem_din=0xC3A5, one req, rom_bytes=2.
REQ-037 mem_ack held off 20 cycles, ioctl_wr every cycle -> ioctl_wait high at occupancy 3, no overflow, all words written in order.
REQ-038 Source ignores ioctl_wait, 6 back-to-back writes, no ack -> overflow=1, words 5..6 dropped.
REQ-039 Stream 0x000..0x14F with valid Tetris-style header (checksum byte 0x0A matching) -> hdr_ok=1; corrupt byte 0x143 -> hdr_ok=0.
REQ-040 Drop cart_download with 3 words buffered -> dl_done single pulse one cycle after third ack; reset asserted mid-REQ -> mem_req=0 next cycle, no dl_done.

Source files
------------

// File: rtl/cart_dl_writer.sv
`timescale 1ns/1ps
// Cartridge download writer: buffers ioctl words in a small FIFO and
// commits them to SDRAM while tracking image size and header checksum.
module cart_dl_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW = 25
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cart_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  output logic [AW-2:0] mem_addr,
  output logic [15:0]   mem_din,
  input  logic          mem_ack,
  output logic [AW-1:0] rom_bytes,
  output logic          hdr_ok,
  output logic          overflow,
  output logic          dl_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = AW - 1 + 16;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] WAIT_CNT = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  state_t        state, state_nxt;
  logic          dl_prev, draining;
  logic [7:0]    csum, csum_base, csum_lo, csum_hi;
  logic [AW-1:0] rom_cand, rom_base;
  logic          full, empty, push, pop, drop;
  logic          dl_start, dl_end;
  logic          hdr_page, hdr_body, hdr_last;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = cart_download & ioctl_wr & ~full;
  assign drop  = cart_download & ioctl_wr & full;
  assign pop   = (state == S_REQ) & mem_ack;
  assign count_nxt = count + (PW+1)'(push) - (PW+1)'(pop);

  assign dl_start = cart_download & ~dl_prev;
  assign dl_end   = ~cart_download & dl_prev;

  assign rom_base = dl_start ? '0 : rom_bytes;
  assign rom_cand = ioctl_addr + AW'(2);

  // Header bytes fold as x = x - b - 1; the last word only folds its low byte.
  assign csum_base = dl_start ? 8'h00 : csum;
  assign csum_lo   = csum_base - ioctl_dout[7:0] - 8'd1;
  assign csum_hi   = csum_lo - ioctl_dout[15:8] - 8'd1;
  assign hdr_page  = (ioctl_addr[AW-1:12] == '0);
  assign hdr_body  = push & hdr_page
                   & (ioctl_addr[11:0] >= 12'h134)
                   & (ioctl_addr[11:0] <= 12'h14A);
  assign hdr_last  = push & hdr_page
                   & (ioctl_addr[11:0] == 12'h14C);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!empty) state_nxt = S_REQ;
      S_REQ:  if (mem_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo[wr_ptr] <= {ioctl_addr[AW-1:1], ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      ioctl_wait <= 1'b0;
      dl_prev    <= 1'b0;
      draining   <= 1'b0;
      dl_done    <= 1'b0;
      csum       <= '0;
      rom_bytes  <= '0;
      hdr_ok     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dl_prev    <= cart_download;
      count      <= count_nxt;
      state      <= state_nxt;
      ioctl_wait <= (count_nxt >= WAIT_CNT);

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (state == S_IDLE && !empty) begin
        mem_req             <= 1'b1;
        {mem_addr, mem_din} <= fifo[rd_ptr];
      end else if (pop) begin
        mem_req <= 1'b0;
      end

      if (push && rom_cand > rom_base) rom_bytes <= rom_cand;
      else                             rom_bytes <= rom_base;

      overflow <= (dl_start ? 1'b0 : overflow) | drop;

      hdr_ok <= dl_start ? 1'b0 : hdr_ok;
      csum   <= csum_base;
      if (hdr_body) csum <= csum_hi;
      if (hdr_last) begin
        csum   <= csum_lo;
        hdr_ok <= (csum_lo == ioctl_dout[15:8]);
      end

      dl_done <= draining & ~cart_download
               & (count_nxt == '0) & (state_nxt == S_IDLE);
      if (dl_start)
        draining <= 1'b0;
      else if (dl_end)
        draining <= 1'b1;
      else if (~cart_download & (count_nxt == '0) & (state_nxt == S_IDLE))
        draining <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cart_dl_writer.sv
`timescale 1ns/1ps
// Bench for cart_dl_writer: directed scenarios plus a randomized phase,
// all checked against a queue-based model of the download stream.
module tb_cart_dl_writer;

  localparam int DEPTH = 4;
  localparam int AW = 25;
  localparam int EW = AW - 1 + 16;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          cart_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [15:0]   ioctl_dout = '0;
  logic          ioctl_wait, mem_req;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] rom_bytes;
  logic          hdr_ok, overflow, dl_done;

  cart_dl_writer #(.FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .cart_download(cart_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
    .rom_bytes(rom_bytes), .hdr_ok(hdr_ok),
    .overflow(overflow), .dl_done(dl_done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: expected contents of the word buffer, in order
  logic [EW-1:0] mq[$];
  logic [EW-1:0] committed[$];
  logic [AW-1:0] m_rom = '0;
  logic [7:0]    m_x = '0;
  logic          m_hdr = 0, m_ovf = 0, m_drain = 0;
  logic          m_dlprev = 0, m_done = 0, prev_req = 0;
  bit            mon_en = 0, saw_wait3 = 0;
  int            cyc = 0, req_rises = 0, done_pulses = 0;
  int            pop_cyc = 0, done_cyc = 0;

  task automatic model_step();
    bit start, fall, acc, drp;
    logic [AW-1:0] a, cand;
    logic [7:0] b;
    if (reset) begin
      mq.delete();
      m_rom = '0; m_x = '0; m_hdr = 0; m_ovf = 0;
      m_drain = 0; m_dlprev = 0; m_done = 0;
      return;
    end
    start = cart_download && !m_dlprev;
    fall  = !cart_download && m_dlprev;
    acc   = cart_download && ioctl_wr && (mq.size() < DEPTH);
    drp   = cart_download && ioctl_wr && (mq.size() >= DEPTH);
    if (mem_ack && mem_req && mq.size() > 0) begin
      committed.push_back(mq.pop_front());
      pop_cyc = cyc;
    end
    if (start) begin
      m_rom = '0; m_x = '0; m_hdr = 0; m_ovf = 0;
    end
    if (acc) begin
      mq.push_back({ioctl_addr[AW-1:1], ioctl_dout});
      cand = ioctl_addr + AW'(2);
      if (cand > m_rom) m_rom = cand;
      if (ioctl_addr < AW'('h1000)) begin
        for (int k = 0; k < 2; k++) begin
          a = ioctl_addr + AW'(k);
          b = (k == 0) ? ioctl_dout[7:0] : ioctl_dout[15:8];
          if (a >= AW'('h134) && a <= AW'('h14C)) m_x = m_x - b - 8'd1;
        end
        if (ioctl_addr == AW'('h14C)) m_hdr = (m_x == ioctl_dout[15:8]);
      end
    end
    if (drp) m_ovf = 1;
    m_done = m_drain && !cart_download && (mq.size() == 0);
    if (start)       m_drain = 0;
    else if (fall)   m_drain = 1;
    else if (m_done) m_drain = 0;
    m_dlprev = cart_download;
  endtask

  always @(negedge clk_sys) begin
    cyc++;
    if (mon_en) begin
      chk("ioctl_wait", ioctl_wait, mq.size() >= DEPTH - 1);
      chk("rom_bytes", rom_bytes, m_rom);
      chk("hdr_ok", hdr_ok, m_hdr);
      chk("overflow", overflow, m_ovf);
      chk("dl_done", dl_done, m_done);
      if (mq.size() == 0) chk("req_nohead", mem_req, 1'b0);
      else if (mem_req) chk("req_word", {mem_addr, mem_din}, mq[0]);
    end
    if (dl_done) begin done_pulses++; done_cyc = cyc; end
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
    if (ioctl_wait && mq.size() == DEPTH - 1) saw_wait3 = 1;
    model_step();
  end

  // SDRAM responder: acks ack_delay cycles after mem_req rises
  int ack_delay = 3;
  bit ack_en = 1, stray_en = 0;
  int wcnt = 0;
  initial forever begin
    @(posedge clk_sys); #1;
    if (mem_req && !mem_ack) begin
      if (ack_en && wcnt >= ack_delay) begin mem_ack = 1; wcnt = 0; end
      else wcnt++;
    end else begin
      mem_ack = stray_en && !mem_req && ($urandom_range(0, 3) == 0);
      wcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [15:0] d,
                     input bit honor);
    int g = 0;
    if (honor) while (ioctl_wait && g < 200) begin tick(); g++; end
    if (g >= 200) chk("wait_timeout", ioctl_wait, 1'b0);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 0;
  endtask

  task automatic drain(input int lim);
    int g = 0;
    while ((mq.size() != 0 || mem_req) && g < lim) begin tick(); g++; end
    chk("drain_timeout", g < lim, 1'b1);
  endtask

  logic [7:0]    img [0:'h14F];
  logic [EW-1:0] e;
  logic [AW-1:0] ra;
  logic [7:0]    x;
  int            c0, r0, d0, g, seq;
  bit            honor;

  initial begin
    reset = 1;
    repeat (3) tick();
    reset = 0;
    @(negedge clk_sys);
    chk("rst_req", mem_req, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", dl_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hdr", hdr_ok, 0);
    chk("rst_rom", rom_bytes, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    mon_en = 1;
    tick();

    // single word, ack 3 cycles after request
    cart_download = 1;
    tick(); tick();
    r0 = req_rises;
    ioctl_wr = 1; ioctl_addr = '0; ioctl_dout = 16'hC3A5;
    tick();
    ioctl_wr = 0;
    @(negedge clk_sys);
    chk("lat_push", mem_req, 0);
    @(negedge clk_sys);
    chk("lat_req", mem_req, 1);
    chk("single_addr", mem_addr, 0);
    chk("single_din", mem_din, 16'hC3A5);
    tick();
    drain(50);
    chk("single_nreq", req_rises - r0, 1);
    chk("single_rom", rom_bytes, 2);

    // slow SDRAM, source writing every cycle it is allowed to
    ack_delay = 20; saw_wait3 = 0; c0 = committed.size();
    for (int i = 0; i < 8; i++) put(AW'('h200 + 2*i), 16'(16'h1000 + i), 1);
    drain(400);
    chk("slow_ovf", overflow, 0);
    chk("slow_wait3", saw_wait3, 1);
    chk("slow_n", committed.size() - c0, 8);
    for (int i = 0; i < 8; i++) begin
      e = {(AW-1)'('h100 + i), 16'(16'h1000 + i)};
      if (committed.size() > c0 + i) chk("slow_order", committed[c0+i], e);
    end

    // source ignores ioctl_wait, no acks: words 5 and 6 dropped
    ack_en = 0; c0 = committed.size();
    for (int i = 0; i < 6; i++) put(AW'('h300 + 2*i), 16'(16'hA000 + i), 0);
    tick();
    @(negedge clk_sys);
    chk("ovf_set", overflow, 1);
    tick();
    ack_en = 1; ack_delay = 1;
    drain(100);
    chk("ovf_n", committed.size() - c0, 4);
    for (int i = 0; i < 4; i++) begin
      e = {(AW-1)'('h180 + i), 16'(16'hA000 + i)};
      if (committed.size() > c0 + i) chk("ovf_order", committed[c0+i], e);
    end

    // header image with a correct checksum, then a corrupted one
    cart_download = 0; tick(); tick();
    cart_download = 1; tick();
    @(negedge clk_sys);
    chk("ovf_clear", overflow, 0);
    tick();
    for (int i = 0; i < 'h150; i++) img[i] = 8'($urandom);
    x = 8'h00;
    for (int a = 'h134; a <= 'h14C; a++) x = x - img[a] - 8'd1;
    img['h14D] = x;
    ack_delay = $urandom_range(0, 2);
    for (int a = 0; a < 'h150; a += 2) put(AW'(a), {img[a+1], img[a]}, 1);
    drain(200);
    @(negedge clk_sys);
    chk("hdr_good", hdr_ok, 1);
    chk("hdr_rom", rom_bytes, 'h150);
    tick();
    d0 = done_pulses; cart_download = 0; g = 0;
    while (done_pulses == d0 && g < 100) begin tick(); g++; end
    chk("hdr_dl_done", done_pulses > d0, 1);
    cart_download = 1; tick();
    img['h143] = img['h143] ^ 8'h5A;
    for (int a = 0; a < 'h14C; a += 2) put(AW'(a), {img[a+1], img[a]}, 1);
    drain(200);
    @(negedge clk_sys);
    chk("hdr_absent", hdr_ok, 0);
    tick();
    for (int a = 'h14C; a < 'h150; a += 2) put(AW'(a), {img[a+1], img[a]}, 1);
    drain(200);
    @(negedge clk_sys);
    chk("hdr_bad", hdr_ok, 0);
    tick();

    // end of download with three words still buffered
    ack_en = 0;
    for (int i = 0; i < 3; i++) put(AW'('h400 + 2*i), 16'(16'h5500 + i), 1);
    d0 = done_pulses; cart_download = 0;
    repeat (5) tick();
    chk("drain_early", done_pulses - d0, 0);
    ack_en = 1; ack_delay = 1;
    repeat (30) tick();
    chk("drain_once", done_pulses - d0, 1);
    chk("drain_lat", done_cyc - pop_cyc, 1);

    // reset while a request is outstanding during drain
    cart_download = 1; tick();
    ack_en = 0;
    put(AW'('h500), 16'h1234, 1);
    put(AW'('h502), 16'h5678, 1);
    cart_download = 0; tick(); tick();
    chk("prerst_req", mem_req, 1);
    d0 = done_pulses;
    reset = 1; tick(); reset = 0;
    @(negedge clk_sys);
    chk("rst_mid_req", mem_req, 0);
    r0 = req_rises;
    stray_en = 1; ack_en = 1;
    repeat (20) tick();
    chk("rst_mid_nodone", done_pulses - d0, 0);
    chk("rst_mid_noreq", req_rises - r0, 0);

    // randomized traffic
    seq = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 79) == 0) cart_download = ~cart_download;
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) ack_delay = $urandom_range(0, 5);
      honor = ($urandom_range(0, 3) != 0);
      ioctl_wr = ($urandom_range(0, 2) != 0) && !(honor && ioctl_wait);
      g = $urandom_range(0, 9);
      if (g < 6) begin
        seq = (seq + 2) & 'h1FFF;
        ra = AW'(seq);
      end else if (g < 9) begin
        ra = AW'($urandom_range('h120, 'h160));
      end else begin
        ra = AW'($urandom);
      end
      ra[0] = 1'b0;
      ioctl_addr = ra;
      ioctl_dout = 16'($urandom);
      tick();
    end
    ioctl_wr = 0; reset = 0; cart_download = 0;
    drain(500);
    stray_en = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
